cmac_tx_arbiter: RTL and testbench
==================================

// Module: cmac_tx_arbiter
//
// PURPOSE
//  Packet-granular round-robin arbiter sharing the CMAC TX AXI-Stream port among NUM_CH requesters.
//  Sits between the user packet sources and the CMAC tx_axis interface, in the CMAC TX clock domain.
//  Holds all traffic while the link is not PCS-aligned and never splits or interleaves a packet.
//  Truncates runaway packets so one faulty source cannot hold the link.
//
// PARAMETERS
//  NUM_CH     2     number of requester channels, legal 1..4
//  DW         512   tdata width in bits; tkeep width is DW/8
//  MAX_BEATS  150   maximum beats per packet before forced truncation, legal 2..65535
//
// PORTS
//  clk             in   1          CMAC TX clock; every port is synchronous to it
//  resetn          in   1          asynchronous, active-low reset
//  link_up         in   1          PCS alignment indication, already synchronous to clk
//  s_axis_tdata    in   NUM_CH*DW  channel i data occupies bits [i*DW +: DW]
//  s_axis_tkeep    in   NUM_CH*DW/8  channel i byte enables occupy bits [i*DW/8 +: DW/8]
//  s_axis_tlast    in   NUM_CH     per-channel end of packet
//  s_axis_tvalid   in   NUM_CH     per-channel valid
//  s_axis_tready   out  NUM_CH     per-channel ready
//  m_axis_tdata    out  DW         to CMAC tx_axis_tdata
//  m_axis_tkeep    out  DW/8       to CMAC tx_axis_tkeep
//  m_axis_tlast    out  1          to CMAC tx_axis_tlast
//  m_axis_tvalid   out  1          to CMAC tx_axis_tvalid
//  m_axis_tready   in   1          from CMAC tx_axis_tready
//  grant           out  NUM_CH     one-hot owner of the current packet; 0 when idle
//  err_oversize    out  1          one-cycle pulse when a packet is truncated
//
// BEHAVIOUR
//  - Reset values:
//    - state = IDLE; rr_ptr = 0; beat count = 0.
//    - grant, s_axis_tready, m_axis_tvalid, m_axis_tlast and err_oversize are all 0.
//  - IDLE:
//    - Waits for link_up = 1 and at least one s_axis_tvalid bit set.
//    - Picks the first valid channel searching rr_ptr, rr_ptr+1, ... modulo NUM_CH.
//    - Registers grant, then goes to PASS. This costs a one-cycle arbitration bubble.
//  - PASS:
//    - Combinational pass-through from the granted channel:
//      m_axis_* = s_axis_*[g]; s_axis_tready[g] = m_axis_tready. All other tready bits are 0.
//    - Beat counter increments on every accepted beat (tvalid & tready).
//    - An accepted beat with tlast set ends the packet: rr_ptr = g+1 modulo NUM_CH, grant = 0, go to IDLE.
//    - Beat number MAX_BEATS accepted without tlast:
//      - m_axis_tlast is forced to 1 on that beat.
//      - err_oversize pulses in the following cycle.
//      - Go to DROP.
//  - DROP:
//    - s_axis_tready[g] = 1 and m_axis_tvalid = 0; the remaining beats of the packet are discarded.
//    - The accepted beat with tlast set: rr_ptr advances, go to IDLE.
//  - link_up:
//    - Sampled only in IDLE.
//    - A link drop mid-packet does not abort: the packet completes, because the CMAC requires whole frames.
//    - No new grant is issued while link_up = 0.
//  - The master side holds data stable under backpressure. The block adds no buffering and no data latency beyond the IDLE bubble.
//  - NUM_CH = 1: rr_ptr is constant 0; everything else is unchanged.
//  - resetn asserted mid-packet:
//    - Outputs drop to their reset values immediately.
//    - The downstream CMAC sees a truncated frame; the system resets the CMAC on the same event.
//
// CONFIGURATION
//  - CMAC_TX_ARB_STATS_EN defined adds the following ports:
//    - pkt_count  out  NUM_CH*32: per-channel count of completed packets, counted at tlast accept (including truncated packets).
//    - drop_count out  32: total number of truncations.
//    - Counters wrap at 2^32, reset to 0, and saturate never.
//  - Macro undefined: the ports and counters are absent; behaviour is otherwise identical.
//
// TESTING
//  1. NUM_CH=2; ch0 and ch1 each queue 3-beat packets, link_up=1, m_axis_tready=1
//     -> output order ch0, ch1, ch0, ch1; one idle cycle between packets; no interleaving.
//  2. link_up=0 with ch0 valid for 100 cycles -> m_axis_tvalid=0 and s_axis_tready=0 throughout;
//     link_up=1 -> grant=01 two cycles later.
//  3. ch1 sends a 10-beat packet; link_up drops at beat 4
//     -> all 10 beats are delivered, tlast on beat 10, then no further grant.
//  4. MAX_BEATS=8; ch0 sends 12 beats with tlast on beat 12
//     -> 8 beats out with tlast forced on beat 8; err_oversize pulses once;
//        beats 9-12 are consumed with m_axis_tvalid=0.
//  5. m_axis_tready toggles 1-0-1-0 during a 4-beat packet
//     -> each beat is presented until accepted; 4 output beats total; data is byte-exact.
//  6. resetn pulsed low at beat 2 of 5 -> grant=0 and m_axis_tvalid=0 within the same cycle;
//     after release, arbitration restarts from ch0.

Source files
------------

// File: rtl/cmac_tx_arbiter.sv
// -----------------------------------------------------------------------------
// cmac_tx_arbiter
//   Packet-granular round-robin arbiter that shares the CMAC TX AXI-Stream port
//   among NUM_CH requesters. A one-cycle IDLE bubble registers the grant; the
//   packet is then passed through combinationally until its tlast. Packets that
//   reach MAX_BEATS beats without tlast are cut (tlast forced) and their tail is
//   drained silently. New grants are only issued while link_up is high.
//
//   Optional build macro: CMAC_TX_ARB_STATS_EN adds per-channel packet counters
//   (pkt_count) and a truncation counter (drop_count).
// -----------------------------------------------------------------------------
module cmac_tx_arbiter #(
  parameter int NUM_CH    = 2,
  parameter int DW        = 512,
  parameter int MAX_BEATS = 150
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   link_up,
  input  logic [NUM_CH*DW-1:0]   s_axis_tdata,
  input  logic [NUM_CH*DW/8-1:0] s_axis_tkeep,
  input  logic [NUM_CH-1:0]      s_axis_tlast,
  input  logic [NUM_CH-1:0]      s_axis_tvalid,
  output logic [NUM_CH-1:0]      s_axis_tready,
  output logic [DW-1:0]          m_axis_tdata,
  output logic [DW/8-1:0]        m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [NUM_CH-1:0]      grant,
  output logic                   err_oversize
`ifdef CMAC_TX_ARB_STATS_EN
  ,
  output logic [NUM_CH*32-1:0]   pkt_count,
  output logic [31:0]            drop_count
`endif
);

  localparam int          PW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int          KW       = DW / 8;
  localparam logic [15:0] LAST_CNT = 16'(MAX_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     gidx_q, gidx_d;       // index of the channel that owns the packet
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [15:0]       cnt_q, cnt_d;         // beats accepted in the current packet
  logic              err_q, err_d;

  logic [PW-1:0]     cand;
  logic [PW-1:0]     pick;
  logic              pick_ok;
  logic              pkt_done;             // source tlast accepted: packet is over
  logic              trunc;                // MAX_BEATS reached without tlast

  // Round-robin search: first valid channel starting at rr_ptr, wrapping modulo NUM_CH
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    cand    = '0;
    pick    = '0;
    pick_ok = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = PW'((int'(rr_ptr_q) + k) % NUM_CH);
      if (s_axis_tvalid[cand]) begin
        pick    = cand;
        pick_ok = 1'b1;
      end
    end
  end

  // Output mux of the owning channel's data and keep
  always_comb begin
    m_axis_tdata = '0;
    m_axis_tkeep = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gidx_q == PW'(c)) begin
        m_axis_tdata = s_axis_tdata[c*DW +: DW];
        m_axis_tkeep = s_axis_tkeep[c*KW +: KW];
      end
    end
  end

  // Next-state logic and handshake steering for IDLE / PASS / DROP
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    gidx_d        = gidx_q;
    grant_d       = grant_q;
    cnt_d         = cnt_q;
    err_d         = 1'b0;
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    pkt_done      = 1'b0;
    trunc         = 1'b0;

    case (state_q)
      IDLE: begin
        if (link_up && pick_ok) begin
          gidx_d        = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          cnt_d         = '0;
          state_d       = PASS;
        end
      end

      PASS: begin
        m_axis_tvalid         = s_axis_tvalid[gidx_q];
        s_axis_tready[gidx_q] = m_axis_tready;
        // The beat that hits the limit carries a forced tlast so the CMAC closes the frame.
        m_axis_tlast          = s_axis_tlast[gidx_q] | (cnt_q == LAST_CNT);
        if (s_axis_tvalid[gidx_q] && m_axis_tready) begin
          cnt_d = cnt_q + 16'd1;
          if (s_axis_tlast[gidx_q]) begin
            pkt_done = 1'b1;
          end else if (cnt_q == LAST_CNT) begin
            trunc   = 1'b1;
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = DROP;
          end
        end
      end

      DROP: begin
        // Tail of a truncated packet is swallowed without reaching the CMAC.
        s_axis_tready[gidx_q] = 1'b1;
        if (s_axis_tvalid[gidx_q] && s_axis_tlast[gidx_q]) begin
          pkt_done = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (pkt_done) begin
      state_d  = IDLE;
      grant_d  = '0;
      cnt_d    = '0;
      rr_ptr_d = PW'((int'(gidx_q) + 1) % NUM_CH);
    end
  end

  // State, pointer, grant and beat-counter registers
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    if (!resetn) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gidx_q   <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gidx_q   <= gidx_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign grant        = grant_q;
  assign err_oversize = err_q;

`ifdef CMAC_TX_ARB_STATS_EN
  logic [NUM_CH*32-1:0] pkt_cnt_q;
  logic [31:0]          drop_cnt_q;

  // Completed-packet and truncation counters; they wrap at 2^32
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (pkt_done && (gidx_q == PW'(c))) begin
          pkt_cnt_q[c*32 +: 32] <= pkt_cnt_q[c*32 +: 32] + 32'd1;
        end
      end
      if (trunc) begin
        drop_cnt_q <= drop_cnt_q + 32'd1;
      end
    end
  end

  assign pkt_count  = pkt_cnt_q;
  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_cmac_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cmac_tx_arbiter
//   Sources are per-channel queues of beats. A packet-level reference model
//   (owner channel, round-robin pointer, truncation flag) predicts grant,
//   handshakes and output beats every cycle; directed scenarios add literal
//   expectations on ordering, beat counts and error pulses.
// -----------------------------------------------------------------------------
module tb_cmac_tx_arbiter;

  localparam int NUM_CH    = 2;
  localparam int DW        = 64;
  localparam int KW        = DW / 8;
  localparam int MAX_BEATS = 8;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    int            idx;     // position of the beat inside its packet
  } beat_t;

  logic                 clk           = 1'b0;
  logic                 resetn        = 1'b0;
  logic                 link_up       = 1'b0;
  logic                 m_axis_tready = 1'b0;
  logic [NUM_CH*DW-1:0] s_axis_tdata  = '0;
  logic [NUM_CH*KW-1:0] s_axis_tkeep  = '0;
  logic [NUM_CH-1:0]    s_axis_tlast  = '0;
  logic [NUM_CH-1:0]    s_axis_tvalid = '0;
  logic [NUM_CH-1:0]    s_axis_tready;
  logic [DW-1:0]        m_axis_tdata;
  logic [KW-1:0]        m_axis_tkeep;
  logic                 m_axis_tlast;
  logic                 m_axis_tvalid;
  logic [NUM_CH-1:0]    grant;
  logic                 err_oversize;

  cmac_tx_arbiter #(
    .NUM_CH    (NUM_CH),
    .DW        (DW),
    .MAX_BEATS (MAX_BEATS)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .link_up       (link_up),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .grant         (grant),
    .err_oversize  (err_oversize)
  );

  always #5 clk = ~clk;

  beat_t             src_q [NUM_CH][$];
  logic [NUM_CH-1:0] pop = '0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int                owner    = -1;
  int                rr       = 0;
  bit                dropping = 1'b0;
  bit                err_exp  = 1'b0;
  bit                have;
  beat_t             hb;
  logic [NUM_CH-1:0] exp_grant;
  logic [NUM_CH-1:0] exp_ready;
  logic              exp_valid;
  int                found;

  // Observation counters (monotonic; scenarios work on deltas)
  int                out_beats    = 0;
  int                out_lasts    = 0;
  int                err_pulses   = 0;
  int                hidden_beats = 0;
  int                gnt_cycles   = 0;
  int                leak_cycles  = 0;
  int                start_log[$];
  logic [NUM_CH-1:0] prev_grant   = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_pkt(input int c, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {$urandom(), $urandom()};
      b.keep = KW'($urandom());
      b.last = (i == len - 1);
      b.idx  = i;
      src_q[c].push_back(b);
    end
  endtask

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int c = 0; c < NUM_CH; c++) if (src_q[c].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    bit done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      done = resetn && (grant == '0) && all_empty();
    end
    check({name, "_idle_timeout"}, 64'(done), 64'd1);
  endtask

  task automatic wait_beats(input string name, input int target, input int budget);
    bit done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      done = (out_beats >= target);
    end
    check({name, "_beat_timeout"}, 64'(done), 64'd1);
  endtask

  // Source driver: retire accepted beats, then present each queue head
  initial forever begin
    @(posedge clk);
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (pop[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
      if (src_q[c].size() > 0) begin
        s_axis_tdata[c*DW +: DW] = src_q[c][0].data;
        s_axis_tkeep[c*KW +: KW] = src_q[c][0].keep;
        s_axis_tlast[c]          = src_q[c][0].last;
        s_axis_tvalid[c]         = 1'b1;
      end else begin
        s_axis_tdata[c*DW +: DW] = '0;
        s_axis_tkeep[c*KW +: KW] = '0;
        s_axis_tlast[c]          = 1'b0;
        s_axis_tvalid[c]         = 1'b0;
      end
    end
  end

  // Compare process: check DUT against the model, then advance the model
  initial forever begin
    @(negedge clk);
    if (!resetn) begin
      check("rst_grant", 64'(grant), 64'd0);
      check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_s_tready", 64'(s_axis_tready), 64'd0);
      check("rst_err", 64'(err_oversize), 64'd0);
      owner      = -1;
      rr         = 0;
      dropping   = 1'b0;
      err_exp    = 1'b0;
      pop        = '0;
      prev_grant = '0;
    end else begin
      exp_grant = '0;
      exp_ready = '0;
      exp_valid = 1'b0;
      have      = 1'b0;
      if (owner >= 0) begin
        exp_grant[owner] = 1'b1;
        have             = s_axis_tvalid[owner];
        if (have) hb = src_q[owner][0];
        exp_ready[owner] = dropping ? 1'b1 : m_axis_tready;
        exp_valid        = have && !dropping;
      end
      check("grant", 64'(grant), 64'(exp_grant));
      check("err_oversize", 64'(err_oversize), 64'(err_exp));
      check("s_tready", 64'(s_axis_tready), 64'(exp_ready));
      check("m_tvalid", 64'(m_axis_tvalid), 64'(exp_valid));
      if (exp_valid) begin
        check("m_tdata", m_axis_tdata, hb.data);
        check("m_tkeep", 64'(m_axis_tkeep), 64'(hb.keep));
        check("m_tlast", 64'(m_axis_tlast), 64'(hb.last || (hb.idx == MAX_BEATS - 1)));
      end

      if (m_axis_tvalid && m_axis_tready) begin
        out_beats++;
        if (m_axis_tlast) out_lasts++;
      end
      if (err_oversize) err_pulses++;
      if ((s_axis_tvalid & s_axis_tready) != '0 && !m_axis_tvalid) hidden_beats++;
      if (grant != '0) gnt_cycles++;
      if (m_axis_tvalid || s_axis_tready != '0) leak_cycles++;
      if (grant != '0 && prev_grant == '0) begin
        for (int c = 0; c < NUM_CH; c++) if (grant[c]) start_log.push_back(c);
      end
      prev_grant = grant;

      err_exp = 1'b0;
      if (owner < 0) begin
        if (link_up && s_axis_tvalid != '0) begin
          found = -1;
          for (int k = 0; k < NUM_CH; k++) begin
            if (found < 0 && s_axis_tvalid[(rr + k) % NUM_CH]) found = (rr + k) % NUM_CH;
          end
          owner = found;
        end
      end else if (have && exp_ready[owner]) begin
        if (hb.last) begin
          rr       = (owner + 1) % NUM_CH;
          owner    = -1;
          dropping = 1'b0;
        end else if (!dropping && hb.idx == MAX_BEATS - 1) begin
          dropping = 1'b1;
          err_exp  = 1'b1;
        end
      end
      pop = s_axis_tvalid & s_axis_tready;
    end
  end

  // Safety net so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  int base_log, base_beats, base_lasts, base_err, base_hidden, base_gnt, base_leak;
  int exp_beats_total, exp_trunc, c_sel, len_sel;

  initial begin
    // Reset state
    #1;
    check("reset_grant", 64'(grant), 64'd0);
    check("reset_s_tready", 64'(s_axis_tready), 64'd0);
    check("reset_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("reset_m_tlast", 64'(m_axis_tlast), 64'd0);
    check("reset_err", 64'(err_oversize), 64'd0);
    repeat (3) @(posedge clk);
    #2;
    resetn = 1'b1;

    // 1: two channels, 3-beat packets, strict alternation
    link_up       = 1'b1;
    m_axis_tready = 1'b1;
    base_log   = start_log.size();
    base_beats = out_beats;
    base_gnt   = gnt_cycles;
    push_pkt(0, 3); push_pkt(0, 3); push_pkt(1, 3); push_pkt(1, 3);
    wait_idle("t1", 200);
    check("t1_packets", 64'(start_log.size() - base_log), 64'd4);
    if (start_log.size() >= base_log + 4) begin
      for (int i = 0; i < 4; i++) check("t1_order", 64'(start_log[base_log + i]), 64'(i % 2));
    end
    check("t1_beats", 64'(out_beats - base_beats), 64'd12);
    check("t1_grant_cycles", 64'(gnt_cycles - base_gnt), 64'd12);

    // 2: link down holds everything; grant follows link_up by the arbitration bubble
    @(posedge clk); #2;
    link_up = 1'b0;
    push_pkt(0, 3);
    base_leak = leak_cycles;
    base_gnt  = gnt_cycles;
    repeat (100) @(posedge clk);
    check("t2_quiet", 64'(leak_cycles - base_leak), 64'd0);
    check("t2_no_grant", 64'(gnt_cycles - base_gnt), 64'd0);
    @(posedge clk); #2;
    link_up = 1'b1;
    @(negedge clk);
    check("t2_grant_early", 64'(grant), 64'd0);
    @(negedge clk);
    check("t2_grant", 64'(grant), 64'b01);
    wait_idle("t2", 50);

    // 3: link drops mid-packet; the packet still completes, then no new grant
    base_beats = out_beats;
    base_lasts = out_lasts;
    push_pkt(1, 6);
    wait_beats("t3", base_beats + 3, 50);
    @(posedge clk); #2;
    link_up = 1'b0;
    wait_idle("t3", 50);
    check("t3_beats", 64'(out_beats - base_beats), 64'd6);
    check("t3_lasts", 64'(out_lasts - base_lasts), 64'd1);
    push_pkt(0, 2);
    base_gnt = gnt_cycles;
    repeat (20) @(posedge clk);
    check("t3_held", 64'(gnt_cycles - base_gnt), 64'd0);
    @(posedge clk); #2;
    link_up = 1'b1;
    wait_idle("t3b", 50);

    // 4: runaway 12-beat packet is cut at MAX_BEATS and its tail drained
    base_beats  = out_beats;
    base_lasts  = out_lasts;
    base_err    = err_pulses;
    base_hidden = hidden_beats;
    push_pkt(0, 12);
    wait_idle("t4", 100);
    check("t4_beats", 64'(out_beats - base_beats), 64'd8);
    check("t4_lasts", 64'(out_lasts - base_lasts), 64'd1);
    check("t4_err_pulses", 64'(err_pulses - base_err), 64'd1);
    check("t4_drained", 64'(hidden_beats - base_hidden), 64'd4);

    // 5: toggling backpressure during a 4-beat packet
    base_beats = out_beats;
    push_pkt(1, 4);
    for (int n = 0; n < 40 && !(all_empty() && grant == '0); n++) begin
      @(posedge clk); #2;
      m_axis_tready = ~m_axis_tready;
    end
    m_axis_tready = 1'b1;
    wait_idle("t5", 20);
    check("t5_beats", 64'(out_beats - base_beats), 64'd4);

    // 6: reset mid-packet; arbitration restarts from channel 0
    base_beats = out_beats;
    push_pkt(1, 5);
    wait_beats("t6", base_beats + 2, 50);
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    check("t6_grant_in_reset", 64'(grant), 64'd0);
    check("t6_tvalid_in_reset", 64'(m_axis_tvalid), 64'd0);
    for (int c = 0; c < NUM_CH; c++) src_q[c].delete();
    repeat (2) @(posedge clk);
    #2;
    resetn   = 1'b1;
    base_log = start_log.size();
    push_pkt(1, 2);
    push_pkt(0, 2);
    wait_idle("t6", 50);
    check("t6_packets", 64'(start_log.size() - base_log), 64'd2);
    if (start_log.size() >= base_log + 2) begin
      check("t6_first_owner", 64'(start_log[base_log]), 64'd0);
      check("t6_second_owner", 64'(start_log[base_log + 1]), 64'd1);
    end

    // Randomized traffic: lengths, backpressure and link flaps
    base_beats      = out_beats;
    base_err        = err_pulses;
    exp_beats_total = 0;
    exp_trunc       = 0;
    for (int n = 0; n < 800; n++) begin
      @(posedge clk); #2;
      m_axis_tready = ($urandom_range(3) != 0);
      link_up       = ($urandom_range(15) != 0);
      if ($urandom_range(2) == 0) begin
        c_sel = $urandom_range(NUM_CH - 1);
        if (src_q[c_sel].size() < 30) begin
          len_sel = $urandom_range(11, 1);
          push_pkt(c_sel, len_sel);
          exp_beats_total += (len_sel < MAX_BEATS) ? len_sel : MAX_BEATS;
          if (len_sel > MAX_BEATS) exp_trunc++;
        end
      end
    end
    link_up       = 1'b1;
    m_axis_tready = 1'b1;
    wait_idle("rand", 3000);
    check("rand_beats", 64'(out_beats - base_beats), 64'(exp_beats_total));
    check("rand_truncations", 64'(err_pulses - base_err), 64'(exp_trunc));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
